fpnew_rounding_arbiter: RTL and testbench
=========================================

// Module: fpnew_rounding_arbiter
// PURPOSE
//  Shares one fpnew_rounding datapath between NumReq requesters (e.g. ADDMUL, DIVSQRT, CAST lanes).
//  Round-robin arbitrates valid/ready requests, rounds the winner and registers the result.
//  Returns the result with the requester index and an opaque tag on a valid/ready output port.
//  Single-cycle latency. Throughput is one result per cycle while out_ready_i stays high.
//  Generates the LFSR advance enable for stochastic modes.
// PARAMETERS
//  NumReq       2    number of requesters (>=2)
//  AbsWidth     2    rounded magnitude width, no sign bit
//  TagWidth     4    opaque per-request tag width
//  EnableRSR    0    enable RSR/RR modes and the LFSR inside the rounding instance
//  RsrPrecision 12   stochastic rounding bits width
//  LfsrWidth    32   LFSR width, passed to the rounding instance
// PORTS
//  clk_i          in   1                  clock
//  rst_i          in   1                  async reset, active-high
//  flush_i        in   1                  drop registered result, synchronous
//  in_valid_i     in   NumReq             request valid, one bit per requester
//  in_ready_o     out  NumReq             request accepted this cycle
//  in_abs_i       in   NumReq*AbsWidth    magnitude before rounding, requester i at [i*AbsWidth +: AbsWidth]
//  in_sign_i      in   NumReq             sign
//  in_rs_i        in   NumReq*2           {round,sticky} bits
//  in_sr_bits_i   in   NumReq*RsrPrecision  stochastic rounding bits
//  in_rnd_mode_i  in   NumReq*3           fpnew_pkg::roundmode_e, packed
//  in_eff_sub_i   in   NumReq             effective subtraction flag
//  in_tag_i       in   NumReq*TagWidth    tag
//  out_valid_o    out  1                  registered result valid
//  out_ready_i    in   1                  consumer ready
//  out_abs_o      out  AbsWidth           rounded magnitude
//  out_sign_o     out  1                  result sign
//  out_zero_o     out  1                  exact-zero flag
//  out_req_id_o   out  $clog2(NumReq)     index of the winning requester
//  out_tag_o      out  TagWidth           tag of the winning request
// BEHAVIOUR
//  Reset: out_valid_o=0; all out_* data=0; in_ready_o=0; priority pointer=0.
//  accept = ~out_valid_o | out_ready_i. It depends only on the output state.
//  Arbitration: among asserted in_valid_i bits, grant the first at or after the pointer, scanning upward with wrap.
//  in_ready_o[i] = accept & grant[i]. A requester may present valid before ready; its payload holds until accepted.
//  Handshake: a transfer occurs when in_valid_i[i] & in_ready_o[i]. At that clock edge:
//   - the winner's request rounds combinationally through fpnew_rounding;
//   - the result, tag and index load into the output register; out_valid_o becomes 1;
//   - the pointer becomes (winner+1) mod NumReq.
//  No transfer: pointer holds.
//  Output drain: out_valid_o & out_ready_i with no new transfer -> out_valid_o clears next cycle.
//  Stall: out_valid_o & ~out_ready_i -> in_ready_o=0; out_* stay stable; pointer frozen.
//  Back-to-back: drain and load in the same cycle is allowed (full throughput).
//  No valid inputs: no grant; the rounding instance sees a don't-care request.
//  en_rsr to rounding instance = transfer & winner mode in {RSR,RR}. The LFSR advances exactly once per stochastic op.
//  EnableRSR=0: RSR/RR requests are accepted; their result is don't-care and the enable stays 0.
//  Rounding: out_abs = abs + round_up, truncated to AbsWidth. All-ones magnitude rounding up wraps to 0; the caller owns overflow.
//  Exact zero: abs==0 & rs==0. If also eff_sub, sign = (mode==RDN).
//  flush_i: clears out_valid_o and blocks acceptance that cycle (in_ready_o=0). Pointer holds. Flush overrides out_ready_i.
//  Async reset mid-operation: outputs clear immediately. The result in flight is lost and no handshake completes.
// STRUCTURE
//  fpnew_pkg: roundmode_e (existing); add function is_stochastic(roundmode_e) returning 1 for RSR/RR.
//  Sub-module fpnew_rr_arb: NumReq round-robin grant, pointer register, one-hot grant and index outputs.
//  Top level: payload mux by grant index, one fpnew_rounding instance, output register.
//  fpnew_rounding takes an active-low reset; top level passes ~rst_i.
// TESTING
//  Defaults unless noted: NumReq=3, AbsWidth=8.
//  1. Only req0: abs=0x2B, rs=10, RNE, tag=5 -> next cycle out_valid=1, abs=0x2C, id=0, tag=5.
//  2. All three valid, out_ready=1 for 6 cycles -> ids 0,1,2,0,1,2, one result per cycle.
//  3. Output valid and out_ready=0 for 3 cycles with 2 requests pending -> in_ready=0 and out_* constant;
//     on release, the pending grant order resumes unchanged.
//  4. abs=0xFF, rs=11, RNE -> abs=0x00. Separately: abs=0x10, rs=01, RUP, sign=1 -> abs=0x10.
//  5. abs=0, rs=00, eff_sub=1, sign=0: RDN -> sign=1, zero=1; RNE -> sign=0, zero=1.
//  6. EnableRSR=1, RSR request with sr_bits=all-ones accepted -> en_rsr pulses 1 cycle.
//     Assert rst_i mid-stall -> out_valid=0 before the next edge; the pointer restarts at req0.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Floating-point shared types: rounding modes and a helper that identifies
// the stochastic modes that consume LFSR randomness.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    RSR = 3'b110,
    RR  = 3'b111
  } roundmode_e;

  function automatic logic is_stochastic(roundmode_e mode);
    return (mode == RSR) || (mode == RR);
  endfunction

endpackage

// File: rtl/fpnew_rounding.sv
// Rounds a magnitude by its {round,sticky} bits under the given mode and
// flags exact zeros; stochastic modes draw on an internal LFSR.
module fpnew_rounding
  import fpnew_pkg::*;
#(
  parameter int unsigned AbsWidth     = 2,
  parameter int unsigned EnableRSR    = 0,
  parameter int unsigned RsrPrecision = 12,
  parameter int unsigned LfsrWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AbsWidth-1:0]     abs_value_i,
  input  logic                    sign_i,
  input  logic [1:0]              round_sticky_bits_i,
  input  logic [RsrPrecision-1:0] stochastic_rounding_bits_i,
  input  roundmode_e              rnd_mode_i,
  input  logic                    effective_subtraction_i,
  input  logic                    en_rsr_i,
  output logic [AbsWidth-1:0]     abs_rounded_o,
  output logic                    sign_o,
  output logic                    exact_zero_o
);

  localparam logic [LfsrWidth-1:0] Taps = LfsrWidth'(32'h8020_0003);

  logic [LfsrWidth-1:0]  r_lfsr;
  logic [RsrPrecision:0] w_sr_sum;
  logic                  w_round_up;
  logic                  w_inexact;

  // With stochastic rounding disabled the LFSR never leaves its seed and folds away.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LfsrWidth'(1);
    end else if ((EnableRSR != 0) && en_rsr_i) begin
      r_lfsr <= {r_lfsr[LfsrWidth-2:0], ^(r_lfsr & Taps)};
    end
  end

  assign w_sr_sum  = {1'b0, stochastic_rounding_bits_i} + {1'b0, r_lfsr[RsrPrecision-1:0]};
  assign w_inexact = |round_sticky_bits_i;

  always_comb begin
    w_round_up = 1'b0;
    unique case (rnd_mode_i)
      RNE: w_round_up = round_sticky_bits_i[1] & (round_sticky_bits_i[0] | abs_value_i[0]);
      RTZ: w_round_up = 1'b0;
      RDN: w_round_up = w_inexact & sign_i;
      RUP: w_round_up = w_inexact & ~sign_i;
      RMM: w_round_up = round_sticky_bits_i[1];
      ROD: w_round_up = w_inexact & ~abs_value_i[0];
      RSR: w_round_up = w_sr_sum[RsrPrecision];
      RR:  w_round_up = w_inexact & r_lfsr[LfsrWidth-1];
      default: w_round_up = 1'b0;
    endcase
  end

  assign abs_rounded_o = abs_value_i + AbsWidth'(w_round_up);
  assign exact_zero_o  = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);
  assign sign_o = (exact_zero_o && effective_subtraction_i) ? (rnd_mode_i == RDN) : sign_i;

endmodule

// File: rtl/fpnew_rr_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer (with wrap); the pointer moves past the winner on each transfer.
module fpnew_rr_arb #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] i_valid,
  input  logic              i_advance,
  output logic [NumReq-1:0] o_grant,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_any
);

  logic [IdxW-1:0] r_ptr;

  always_comb begin : p_grant
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NumReq) j = j - NumReq;
      if (!o_any && i_valid[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_idx == IdxW'(NumReq - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fpnew_rounding_arbiter.sv
// Shares one rounding datapath among NumReq requesters: round-robin grant,
// combinational rounding of the winner, single registered output stage.
module fpnew_rounding_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned AbsWidth     = 2,
  parameter int unsigned TagWidth     = 4,
  parameter int unsigned EnableRSR    = 0,
  parameter int unsigned RsrPrecision = 12,
  parameter int unsigned LfsrWidth    = 32,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NumReq-1:0]              in_valid_i,
  output logic [NumReq-1:0]              in_ready_o,
  input  logic [NumReq*AbsWidth-1:0]     in_abs_i,
  input  logic [NumReq-1:0]              in_sign_i,
  input  logic [NumReq*2-1:0]            in_rs_i,
  input  logic [NumReq*RsrPrecision-1:0] in_sr_bits_i,
  input  logic [NumReq*3-1:0]            in_rnd_mode_i,
  input  logic [NumReq-1:0]              in_eff_sub_i,
  input  logic [NumReq*TagWidth-1:0]     in_tag_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [AbsWidth-1:0]            out_abs_o,
  output logic                           out_sign_o,
  output logic                           out_zero_o,
  output logic [IdxW-1:0]                out_req_id_o,
  output logic [TagWidth-1:0]            out_tag_o
);

  logic [NumReq-1:0]       w_grant;
  logic [IdxW-1:0]         w_idx;
  logic                    w_any;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_en_rsr;
  logic [AbsWidth-1:0]     w_abs;
  logic                    w_sign;
  logic [1:0]              w_rs;
  logic [RsrPrecision-1:0] w_sr;
  roundmode_e              w_mode;
  logic                    w_eff;
  logic [TagWidth-1:0]     w_tag;
  logic [AbsWidth-1:0]     w_rnd_abs;
  logic                    w_rnd_sign;
  logic                    w_rnd_zero;

  // Acceptance looks only at the output stage; reset and flush both block it.
  assign w_accept   = (~out_valid_o | out_ready_i) & ~flush_i & ~rst_i;
  assign w_xfer     = w_accept & w_any;
  assign in_ready_o = {NumReq{w_accept}} & w_grant;
  assign w_en_rsr   = (EnableRSR != 0) & w_xfer & is_stochastic(w_mode);

  fpnew_rr_arb #(.NumReq(NumReq)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_valid   (in_valid_i),
    .i_advance (w_xfer),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_abs  = '0;
    w_sign = 1'b0;
    w_rs   = '0;
    w_sr   = '0;
    w_mode = RNE;
    w_eff  = 1'b0;
    w_tag  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_grant[i]) begin
        w_abs  = in_abs_i[i*AbsWidth +: AbsWidth];
        w_sign = in_sign_i[i];
        w_rs   = in_rs_i[i*2 +: 2];
        w_sr   = in_sr_bits_i[i*RsrPrecision +: RsrPrecision];
        w_mode = roundmode_e'(in_rnd_mode_i[i*3 +: 3]);
        w_eff  = in_eff_sub_i[i];
        w_tag  = in_tag_i[i*TagWidth +: TagWidth];
      end
    end
  end

  fpnew_rounding #(
    .AbsWidth     (AbsWidth),
    .EnableRSR    (EnableRSR),
    .RsrPrecision (RsrPrecision),
    .LfsrWidth    (LfsrWidth)
  ) u_round (
    .clk_i                      (clk_i),
    .rst_ni                     (~rst_i),
    .abs_value_i                (w_abs),
    .sign_i                     (w_sign),
    .round_sticky_bits_i        (w_rs),
    .stochastic_rounding_bits_i (w_sr),
    .rnd_mode_i                 (w_mode),
    .effective_subtraction_i    (w_eff),
    .en_rsr_i                   (w_en_rsr),
    .abs_rounded_o              (w_rnd_abs),
    .sign_o                     (w_rnd_sign),
    .exact_zero_o               (w_rnd_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o  <= 1'b0;
      out_abs_o    <= '0;
      out_sign_o   <= 1'b0;
      out_zero_o   <= 1'b0;
      out_req_id_o <= '0;
      out_tag_o    <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (w_xfer) begin
      out_valid_o  <= 1'b1;
      out_abs_o    <= w_rnd_abs;
      out_sign_o   <= w_rnd_sign;
      out_zero_o   <= w_rnd_zero;
      out_req_id_o <= w_idx;
      out_tag_o    <= w_tag;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpnew_rounding_arbiter.sv
// Directed bench for the rounding arbiter: a reference arbitration/rounding
// model pushes expected results that are popped as the output drains.
module tb_fpnew_rounding_arbiter;

  localparam int N = 3;

  typedef struct {
    logic [7:0] abs;
    logic       sign;
    logic       zero;
    logic [1:0] id;
    logic [3:0] tag;
    bit         chk_abs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [23:0] in_abs;
  logic [2:0]  in_sign;
  logic [5:0]  in_rs;
  logic [35:0] in_sr;
  logic [8:0]  in_mode;
  logic [2:0]  in_eff;
  logic [11:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_abs;
  logic        out_sign;
  logic        out_zero;
  logic [1:0]  out_id;
  logic [3:0]  out_tag;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  bit   m_valid;
  int   m_ptr;

  always #5 clk = ~clk;

  fpnew_rounding_arbiter #(
    .NumReq(3), .AbsWidth(8), .TagWidth(4), .EnableRSR(1), .RsrPrecision(12), .LfsrWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_abs_i(in_abs),
    .in_sign_i(in_sign), .in_rs_i(in_rs), .in_sr_bits_i(in_sr),
    .in_rnd_mode_i(in_mode), .in_eff_sub_i(in_eff), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_abs_o(out_abs),
    .out_sign_o(out_sign), .out_zero_o(out_zero), .out_req_id_o(out_id),
    .out_tag_o(out_tag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [1:0] rs,
                         input logic [2:0] md, input logic s, input logic eff,
                         input logic [3:0] tg, input logic [11:0] sr);
    in_abs[i*8 +: 8]   = a;
    in_rs[i*2 +: 2]    = rs;
    in_mode[i*3 +: 3]  = md;
    in_sign[i]         = s;
    in_eff[i]          = eff;
    in_tag[i*4 +: 4]   = tg;
    in_sr[i*12 +: 12]  = sr;
  endtask

  // Reference rounding of requester w's current payload.
  task automatic push_exp(input int w);
    exp_t       e;
    logic [7:0] a;
    logic [1:0] rs;
    logic [2:0] md;
    logic       s, ru;
    a  = in_abs[w*8 +: 8];
    rs = in_rs[w*2 +: 2];
    md = in_mode[w*3 +: 3];
    s  = in_sign[w];
    case (md)
      3'd0:    ru = rs[1] && (rs[0] || a[0]);
      3'd2:    ru = (rs != 0) && s;
      3'd3:    ru = (rs != 0) && !s;
      3'd4:    ru = rs[1];
      3'd5:    ru = (rs != 0) && !a[0];
      default: ru = 1'b0;
    endcase
    e.abs     = a + {7'd0, ru};
    e.zero    = (a == 0) && (rs == 0);
    e.sign    = (e.zero && in_eff[w]) ? (md == 3'd2) : s;
    e.id      = 2'(w);
    e.tag     = in_tag[w*4 +: 4];
    e.chk_abs = (md < 3'd6);
    q.push_back(e);
  endtask

  // One clock: check outputs and handshake at the falling edge, advance the model.
  task automatic cycle();
    bit   acc, xfer;
    int   w, j;
    exp_t e;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid && q.size() > 0) begin
      e = q[0];
      chk("out_id", {30'd0, out_id}, {30'd0, e.id});
      chk("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
      chk("out_sign", {31'd0, out_sign}, {31'd0, e.sign});
      chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
      if (e.chk_abs) chk("out_abs", {24'd0, out_abs}, {24'd0, e.abs});
    end
    acc = (!m_valid || out_ready) && !flush;
    w = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && in_valid[j]) w = j;
    end
    xfer = acc && (w >= 0);
    chk("in_ready", {29'd0, in_ready}, xfer ? (32'd1 << w) : 32'd0);
    chk("en_rsr", {31'd0, dut.w_en_rsr}, {31'd0, xfer && (in_mode[w*3 +: 3] >= 3'd6)});
    if (m_valid && (flush || out_ready)) begin
      void'(q.pop_front());
      m_valid = 1'b0;
    end
    if (xfer) begin
      push_exp(w);
      m_ptr   = (w + 1) % N;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 3'b111; in_abs = '0; in_sign = '0; in_rs = '0;
    in_sr = '0; in_mode = '0; in_eff = '0; in_tag = '0;
    m_valid = 1'b0; m_ptr = 0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {29'd0, in_ready}, 32'd0);
    chk("rst_out_abs", {24'd0, out_abs}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_id", {30'd0, out_id}, 32'd0);
    in_valid = 3'b000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    // Single request from req0
    set_req(0, 8'h2B, 2'b10, 3'd0, 1'b0, 1'b0, 4'd5, 12'h0);
    in_valid = 3'b001;
    cycle();
    in_valid = 3'b000;
    chk("t1_abs_2C", {24'd0, out_abs}, 32'h2C);
    cycle();

    // Wrap of all-ones magnitude, then RUP on a negative value
    set_req(1, 8'hFF, 2'b11, 3'd0, 1'b0, 1'b0, 4'd1, 12'h0);
    in_valid = 3'b010;
    cycle();
    chk("t4_wrap_00", {24'd0, out_abs}, 32'h00);
    set_req(2, 8'h10, 2'b01, 3'd3, 1'b1, 1'b0, 4'd2, 12'h0);
    in_valid = 3'b100;
    cycle();
    chk("t4_rup_neg_10", {24'd0, out_abs}, 32'h10);
    in_valid = 3'b000;
    cycle();

    // Three contending requesters at full throughput
    set_req(0, 8'h01, 2'b11, 3'd4, 1'b0, 1'b0, 4'hA, 12'h0);
    set_req(1, 8'h02, 2'b01, 3'd5, 1'b0, 1'b0, 4'hB, 12'h0);
    set_req(2, 8'h03, 2'b10, 3'd0, 1'b0, 1'b0, 4'hC, 12'h0);
    in_valid = 3'b111;
    for (int c = 0; c < 6; c++) cycle();

    // Stall with two pending requests, then release
    in_valid = 3'b110; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    out_ready = 1'b1;
    cycle();
    chk("t3_resume_id1", {30'd0, out_id}, 32'd1);
    cycle();
    chk("t3_resume_id2", {30'd0, out_id}, 32'd2);
    in_valid = 3'b000;
    cycle();

    // Exact zero under effective subtraction
    set_req(0, 8'h00, 2'b00, 3'd2, 1'b0, 1'b1, 4'd4, 12'h0);
    in_valid = 3'b001;
    cycle();
    chk("t5_rdn_sign", {31'd0, out_sign}, 32'd1);
    set_req(0, 8'h00, 2'b00, 3'd0, 1'b0, 1'b1, 4'd6, 12'h0);
    cycle();
    chk("t5_rne_sign", {31'd0, out_sign}, 32'd0);
    in_valid = 3'b000;
    cycle();

    // Flush drops a stalled result and blocks acceptance
    set_req(2, 8'h40, 2'b00, 3'd1, 1'b0, 1'b0, 4'd7, 12'h0);
    in_valid = 3'b100; out_ready = 1'b0;
    cycle();
    in_valid = 3'b011; flush = 1'b1;
    cycle();
    flush = 1'b0; out_ready = 1'b1;
    cycle();
    in_valid = 3'b000;
    cycle();

    // Stochastic request pulses the LFSR enable once
    set_req(1, 8'h05, 2'b11, 3'd6, 1'b0, 1'b0, 4'd9, 12'hFFF);
    in_valid = 3'b010;
    cycle();
    in_valid = 3'b000;
    cycle();

    // Reset during a stall
    set_req(0, 8'h33, 2'b00, 3'd0, 1'b0, 1'b0, 4'd3, 12'h0);
    in_valid = 3'b001; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {29'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m_valid = 1'b0; m_ptr = 0; q.delete();
    out_ready = 1'b1; in_valid = 3'b111;
    cycle();
    chk("post_rst_id0", {30'd0, out_id}, 32'd0);
    in_valid = 3'b000;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
